// File: rtl/sp_instr_fifo.sv
// rtl/sp_instr_fifo.sv - show-ahead instruction FIFO between scratchpad dispatch and bank access FSM
// Optional same-cycle forwarding into an empty FIFO: define SP_INSTR_FIFO_BYPASS_EN.
module sp_instr_fifo #(
  parameter int  DEPTH       = 8,
  parameter type instrFIFO_t = logic [31:0]
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     instr_WEN,
  input  instrFIFO_t               instr_wdata,
  input  logic                     flush,
  input  logic                     instrFIFO_REN,
  output instrFIFO_t               instrFIFO_rdata,
  output logic                     instrFIFO_empty,
  output logic                     instrFIFO_full,
  output logic                     new_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          new_instr_q, new_instr_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  instrFIFO_t    mem_q [DEPTH];

  logic stored_empty, stored_full, bypass;
  logic push_ok, pop_ok, mem_we;

  assign stored_empty = (count_q == '0);
  assign stored_full  = (count_q == CW'(DEPTH));

  // A push into an empty FIFO is presented at the head in the same cycle.
`ifdef SP_INSTR_FIFO_BYPASS_EN
  assign bypass = instr_WEN & stored_empty & ~flush;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    new_instr_d = 1'b0;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    push_ok     = 1'b0;
    pop_ok      = 1'b0;
    mem_we      = 1'b0;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      pop_ok  = instrFIFO_REN & ~stored_empty;
      push_ok = instr_WEN & (~stored_full | instrFIFO_REN);
      ovf_d   = ovf_q | (instr_WEN & stored_full & ~instrFIFO_REN);
      unf_d   = unf_q | (instrFIFO_REN & stored_empty & ~bypass);
      new_instr_d = (push_ok & stored_empty & ~bypass)
                  | (pop_ok & (count_q >= CW'(2)));
      // A forwarded entry consumed in the same cycle never touches storage.
      if (bypass & instrFIFO_REN) push_ok = 1'b0;
      mem_we = push_ok;
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      new_instr_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      new_instr_q <= new_instr_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[wptr_q] <= instr_wdata;
  end

  assign instrFIFO_rdata = bypass ? instr_wdata : mem_q[rptr_q];
  assign instrFIFO_empty = stored_empty & ~bypass;
  assign instrFIFO_full  = stored_full;
  assign new_instr       = new_instr_q | bypass;
  assign count           = count_q;
  assign overflow_err    = ovf_q;
  assign underflow_err   = unf_q;

endmodule

// File: tb/tb_sp_instr_fifo.sv
// tb/tb_sp_instr_fifo.sv - scoreboard bench for sp_instr_fifo
module tb_sp_instr_fifo;

  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        wen = 1'b0, ren = 1'b0, fl = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        empty, full, new_i, ovf, unf;
  logic [3:0]  cnt;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] mdl_q[$];
  logic [31:0] exp_q[$];
  logic        m_new = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

  sp_instr_fifo #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .instr_WEN(wen), .instr_wdata(wdata), .flush(fl),
    .instrFIFO_REN(ren), .instrFIFO_rdata(rdata), .instrFIFO_empty(empty),
    .instrFIFO_full(full), .new_instr(new_i), .count(cnt),
    .overflow_err(ovf), .underflow_err(unf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, flags from the transaction rules.
  always @(posedge CLK or negedge nRST) begin
    int  n;
    logic byp;
    if (!nRST) begin
      mdl_q.delete(); exp_q.delete();
      m_new <= 1'b0; m_ovf <= 1'b0; m_unf <= 1'b0;
    end else if (fl) begin
      mdl_q.delete(); exp_q.delete();
      m_new <= 1'b0;
    end else begin
      n = mdl_q.size();
      byp = 1'b0;
`ifdef SP_INSTR_FIFO_BYPASS_EN
      byp = wen && (n == 0);
`endif
      if (byp) begin
        m_new <= 1'b0;
        if (!ren) begin mdl_q.push_back(wdata); exp_q.push_back(wdata); end
      end else begin
        m_new <= (wen && n == 0) || (ren && n >= 2);
        if (wen && n == DEPTH && !ren) m_ovf <= 1'b1;
        if (ren && n == 0) m_unf <= 1'b1;
        if (ren && n > 0) void'(mdl_q.pop_front());
        if (wen && (n < DEPTH || ren)) begin
          mdl_q.push_back(wdata); exp_q.push_back(wdata);
        end
      end
    end
  end

  // Monitor: compares outputs mid-cycle; pops the scoreboard on each DUT pop.
  always @(negedge CLK) begin
    int n;
    logic byp;
    logic [31:0] e;
    n = mdl_q.size();
    byp = 1'b0;
`ifdef SP_INSTR_FIFO_BYPASS_EN
    byp = nRST && wen && !fl && (n == 0);
`endif
    chk("count", 32'(cnt), 32'(n));
    chk("empty", 32'(empty), 32'((n == 0) && !byp));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("new_instr", 32'(new_i), 32'(m_new || byp));
    chk("overflow_err", 32'(ovf), 32'(m_ovf));
    chk("underflow_err", 32'(unf), 32'(m_unf));
    if (nRST) begin
      if (byp) chk("rdata_bypass", rdata, wdata);
      else if (ren && !fl && !empty) begin
        if (exp_q.size() == 0) chk("scoreboard_underrun", 32'(exp_q.size()), 32'd1);
        else begin e = exp_q.pop_front(); chk("rdata_pop", rdata, e); end
      end else if (n > 0) chk("rdata_head", rdata, mdl_q[0]);
    end
  end

  task automatic step(input logic w, input logic [31:0] d, input logic r, input logic f);
    wen = w; wdata = d; ren = r; fl = f;
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, z, q;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;

    // push A into empty FIFO
    a = 32'hA0A0_0001;
    step(1, a, 0, 0);
`ifndef SP_INSTR_FIFO_BYPASS_EN
    chk("s1_empty", 32'(empty), 0);
    chk("s1_rdata", rdata, a);
    chk("s1_new", 32'(new_i), 1);
    chk("s1_count", 32'(cnt), 1);
`endif
    step(0, 0, 0, 0);
    chk("s1_new_t2", 32'(new_i), 0);

    // fill, then overflow
    for (int i = 1; i < DEPTH; i++) step(1, $urandom, 0, 0);
    step(1, 32'hDEAD_BEEF, 0, 0);
    chk("s2_full", 32'(full), 1);
    chk("s2_count", 32'(cnt), DEPTH);
    chk("s2_ovf", 32'(ovf), 1);
    chk("s2_head", rdata, a);

    // simultaneous push/pop while full
    for (int i = 0; i < 20; i++) step(1, $urandom, 1, 0);
    chk("s3_count", 32'(cnt), DEPTH);
    chk("s3_unf", 32'(unf), 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);

    // underflow is sticky through flush
    step(0, 0, 1, 0);
    chk("s4_unf", 32'(unf), 1);
    step(0, 0, 0, 1);
    chk("s4_unf_flush", 32'(unf), 1);

    // reset with entries held
    for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0);
    step(0, 0, 0, 0);
    #2 nRST = 1'b0;
    #1;
    chk("rst_count", 32'(cnt), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_flags", {30'd0, ovf, unf}, 0);
    @(posedge CLK); #1 nRST = 1'b1;
    q = 32'h1234_5678;
    step(1, q, 0, 0);
    chk("rst_slot0", dut.mem_q[0], q);

    // flush beats a same-cycle push
    for (int i = 1; i < 5; i++) step(1, $urandom, 0, 0);
    chk("s5_count5", 32'(cnt), 5);
    z = 32'h5555_AAAA;
    step(1, z, 0, 1);
    chk("s5_count", 32'(cnt), 0);
    chk("s5_empty", 32'(empty), 1);
    chk("s5_flags", {30'd0, ovf, unf}, 0);
    chk("s5_wptr", 32'(dut.wptr_q), 0);
    q = 32'hC0DE_0005;
    step(1, q, 0, 0);
    chk("s5_slot0", dut.mem_q[0], q);
    step(0, 0, 0, 1);

`ifdef SP_INSTR_FIFO_BYPASS_EN
    wen = 1; wdata = 32'hBBBB_0002; ren = 1; fl = 0;
    @(negedge CLK); #1;
    chk("byp_rdata", rdata, 32'hBBBB_0002);
    chk("byp_new", 32'(new_i), 1);
    @(posedge CLK); #1;
    chk("byp_count", 32'(cnt), 0);
    chk("byp_unf", 32'(unf), 0);
`endif

    // randomized traffic with shifting push/pop bias
    for (int i = 0; i < 1500; i++) begin
      int wp, rp;
      wp = ((i / 100) % 2 == 0) ? 70 : 35;
      rp = 100 - wp;
      step($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp,
           $urandom_range(0, 99) < 2);
    end
    step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
